// File: rtl/div_unit.sv
// ============================================================================
// Module   : div_unit
// Purpose  : Iterative restoring divider, signed/unsigned, one quotient bit
//            per cycle, with divide-by-zero and signed-overflow handling.
// Revision : 1.0
// ============================================================================
`default_nettype none

module div_unit #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  signed_op,
    input  logic [DATA_WIDTH-1:0] dividend,
    input  logic [DATA_WIDTH-1:0] divisor,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] quotient,
    output logic [DATA_WIDTH-1:0] remainder,
    output logic                  div_by_zero
);

    localparam int               CNT_W    = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic [CNT_W-1:0]      r_cnt;
    logic [DATA_WIDTH-1:0] r_rem;
    logic [DATA_WIDTH-1:0] r_quo;
    logic [DATA_WIDTH-1:0] r_dvs;
    logic                  r_neg_q;
    logic                  r_neg_r;

    logic                  w_accept;
    logic                  w_div_zero;
    logic [DATA_WIDTH-1:0] w_a_mag;
    logic [DATA_WIDTH-1:0] w_b_mag;
    logic [DATA_WIDTH:0]   w_shift;
    logic [DATA_WIDTH:0]   w_diff;
    logic                  w_sub_ok;

    assign w_accept   = start && ((r_state == IDLE) || (r_state == DONE));
    assign w_div_zero = (divisor == '0);

    // Negating MIN yields MIN, which read as unsigned is exactly 2^(W-1).
    assign w_a_mag = (signed_op && dividend[DATA_WIDTH-1]) ? -dividend : dividend;
    assign w_b_mag = (signed_op && divisor[DATA_WIDTH-1])  ? -divisor  : divisor;

    // Trial subtraction on the (W+1)-bit shifted partial remainder.
    assign w_shift  = {r_rem, r_quo[DATA_WIDTH-1]};
    assign w_diff   = w_shift - {1'b0, r_dvs};
    assign w_sub_ok = ~w_diff[DATA_WIDTH];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        busy   = 1'b0;
        done   = 1'b0;
        case (r_state)
            IDLE, DONE: begin
                done   = (r_state == DONE);
                w_next = IDLE;
                if (w_accept) begin
                    w_next = w_div_zero ? DONE : RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (r_cnt == LAST_CNT) begin
                    w_next = FIX;
                end
            end
            FIX: begin
                busy   = 1'b1;
                w_next = DONE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt       <= '0;
            r_rem       <= '0;
            r_quo       <= '0;
            r_dvs       <= '0;
            r_neg_q     <= 1'b0;
            r_neg_r     <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (w_accept) begin
                        r_cnt   <= '0;
                        r_rem   <= '0;
                        r_quo   <= w_a_mag;
                        r_dvs   <= w_b_mag;
                        r_neg_q <= signed_op & (dividend[DATA_WIDTH-1] ^ divisor[DATA_WIDTH-1]);
                        r_neg_r <= signed_op & dividend[DATA_WIDTH-1];
                        if (w_div_zero) begin
                            quotient    <= '1;
                            remainder   <= dividend;
                            div_by_zero <= 1'b1;
                        end else begin
                            div_by_zero <= 1'b0;
                        end
                    end
                end
                RUN: begin
                    r_rem <= w_sub_ok ? w_diff[DATA_WIDTH-1:0] : w_shift[DATA_WIDTH-1:0];
                    r_quo <= {r_quo[DATA_WIDTH-2:0], w_sub_ok};
                    r_cnt <= r_cnt + 1'b1;
                end
                FIX: begin
                    quotient  <= r_neg_q ? -r_quo : r_quo;
                    remainder <= r_neg_r ? -r_rem : r_rem;
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire
